store_align_unit: RTL and testbench
===================================

# store_align_unit

Store-path counterpart of the load width/extension logic. Takes one store (SB/SH/SW) from the execute stage over a valid/ready handshake and places the rs2 bytes on the correct byte lanes with write strobes. It drives a word-addressed data-memory write port with a req/ack handshake, splitting misaligned halfword/word stores into two aligned word writes. It signals completion or an illegal-width error back to the core.

## Interface
- No parameters; address and data are fixed at 32 bits, and the memory port is 4 byte lanes.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  unit can accept a request (high only in IDLE)
- st_funct3  in  3  store width: 000 SB, 001 SH, 010 SW, others illegal
- st_addr  in  32  byte address
- st_data  in  32  rs2 value; the store uses its low 1/2/4 bytes
- st_done  out  1  one-cycle pulse: all beats of the store acknowledged
- st_err  out  1  one-cycle pulse: illegal funct3, no memory access made
- mem_req  out  1  write request, held until mem_ack
- mem_addr  out  32  word-aligned address (bits [1:0] always 00)
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte-lane enables; bit i enables mem_wdata[8i+7:8i]
- mem_ack  in  1  memory accepted the current beat

## Operation
- Accept when st_valid && st_ready. Register funct3, addr, and data. Requests are ignored outside IDLE.
- Size mask m: SB 0001, SH 0011, SW 1111. Offset o = addr[1:0].
- Form the 8-lane strobe S = {4'b0, m} << o.
- Form the 64-bit data D = {32'b0, data & bytemask(m)} << (8*o).
- Beat 0: mem_addr = {addr[31:2], 2'b00}, mem_wstrb = S[3:0], mem_wdata = D[31:0].
- Beat 1, issued only if S[7:4] != 0: mem_addr = beat-0 address + 4 (wraps modulo 2^32), mem_wstrb = S[7:4], mem_wdata = D[63:32].
- Data lanes with a zero strobe are driven as 0.
- States:
  - IDLE: st_ready=1. Legal accept → BEAT0. Illegal accept → ERR.
  - BEAT0: mem_req=1. On mem_ack → BEAT1 if split, else RESP.
  - BEAT1: mem_req=1. On mem_ack → RESP.
  - RESP: st_done=1 for one cycle → IDLE.
  - ERR: st_err=1 for one cycle → IDLE.
- mem_addr, mem_wdata, and mem_wstrb are stable while mem_req=1 and not yet acked.
- mem_req drops or changes beat the cycle after mem_ack.
- mem_ack is ignored in IDLE, RESP, and ERR.

## Timing
- All outputs are registered except st_ready, which is decoded from state.
- Reset values: state IDLE, st_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, st_done=0, st_err=0.
- Accept at edge N → mem_req=1 from cycle N+1.
- mem_ack sampled high at edge N+k: the next beat's req is visible at N+k+1, or st_done is visible at N+k+1.
- Minimum latency, aligned store with ack on the first req cycle: accept N, req N+1, st_done N+2, st_ready N+3.
- Minimum latency, split store: st_done at N+3.
- Illegal funct3: st_err at N+1, st_ready at N+2, mem_req never asserts.
- Asynchronous reset mid-transfer: all outputs go to reset values immediately. The in-flight beat is abandoned and no st_done is issued. The memory side is reset by the same rst_n.
- Split store: beat 0 always completes before beat 1 is presented (no reordering).
- mem_req may stay high indefinitely; there is no timeout.

## Test plan
- SB, addr=0x1003, data=0xAABBCCDD, ack on the first req cycle → one beat: addr 0x1000, wstrb 1000, wdata 0xDD000000. st_done pulses 2 cycles after accept.
- SH, addr=0x2002, data=0x00001234 → one beat: addr 0x2000, wstrb 1100, wdata 0x12340000. SW at 0x2004 with data 0xCAFEF00D → addr 0x2004, wstrb 1111, wdata 0xCAFEF00D.
- SW, addr=0x3001, data=0x11223344 → beat 0: 0x3000 / 1110 / 0x22334400. Beat 1: 0x3004 / 0001 / 0x00000011. st_done once, after the second ack.
- SH, addr=0xFFFFFFFF, data=0xBEEF, ack delayed 3 cycles per beat → beat 0: 0xFFFFFFFC / 1000 / 0xEF000000, held 3 cycles. Beat 1: 0x00000000 / 0001 / 0x000000BE. st_ready=0 throughout.
- funct3=011 with st_valid → st_err pulse next cycle, mem_req stays 0. A following legal SB is accepted normally.
- rst_n dropped while BEAT1 is waiting on ack → mem_req=0 and st_ready=1 asynchronously, no st_done. After release, a new SW at 0x0 completes in 2 cycles.

Source files
------------

// File: rtl/store_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_align_unit: aligns SB/SH/SW stores onto word lanes, splitting any     |
// | store that crosses a word boundary into two aligned writes.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module store_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        st_done_q;
  logic        st_err_q;
  logic [31:0] hi_addr_q;
  logic [31:0] hi_wdata_q;
  logic [3:0]  hi_wstrb_q;

  logic        w_legal;
  logic [3:0]  w_size_mask;
  logic [31:0] w_byte_mask;
  logic [7:0]  w_strb8;
  logic [63:0] w_data64;
  logic [31:0] w_word_addr;

  always_comb begin
    w_legal     = 1'b1;
    w_size_mask = 4'b1111;
    case (st_funct3)
      3'b000:  w_size_mask = 4'b0001;
      3'b001:  w_size_mask = 4'b0011;
      3'b010:  w_size_mask = 4'b1111;
      default: w_legal     = 1'b0;
    endcase
    w_byte_mask = {{8{w_size_mask[3]}}, {8{w_size_mask[2]}},
                   {8{w_size_mask[1]}}, {8{w_size_mask[0]}}};
    // Shifting into an 8-lane window exposes the spill into the next word.
    w_strb8     = {4'b0000, w_size_mask} << st_addr[1:0];
    w_data64    = {32'h0, st_data & w_byte_mask} << {st_addr[1:0], 3'b000};
    w_word_addr = {st_addr[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      hi_addr_q   <= 32'h0;
      hi_wdata_q  <= 32'h0;
      hi_wstrb_q  <= 4'h0;
    end else begin
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (st_valid) begin
            if (w_legal) begin
              state_q     <= S_BEAT0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= w_word_addr;
              mem_wstrb_q <= w_strb8[3:0];
              mem_wdata_q <= w_data64[31:0];
              hi_addr_q   <= w_word_addr + 32'd4;
              hi_wstrb_q  <= w_strb8[7:4];
              hi_wdata_q  <= w_data64[63:32];
            end else begin
              state_q  <= S_ERR;
              st_err_q <= 1'b1;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ack) begin
            if (hi_wstrb_q != 4'h0) begin
              state_q     <= S_BEAT1;
              mem_addr_q  <= hi_addr_q;
              mem_wstrb_q <= hi_wstrb_q;
              mem_wdata_q <= hi_wdata_q;
            end else begin
              state_q     <= S_RESP;
              mem_req_q   <= 1'b0;
              mem_addr_q  <= 32'h0;
              mem_wstrb_q <= 4'h0;
              mem_wdata_q <= 32'h0;
              st_done_q   <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (mem_ack) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'h0;
            st_done_q   <= 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign st_ready  = (state_q == S_IDLE);
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_store_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_store_align_unit: byte-level reference model with a randomly stalling    |
// | memory responder.  Rev 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_store_align_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  int checks;
  int failures;

  logic [31:0] e_addr [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_strb [2];
  int          e_n;

  store_align_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Place each byte at its own address, then group bytes by containing word.
  task automatic build_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int nb;
    logic [31:0] ba;
    logic [31:0] w;
    int lane;
    nb  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    e_n = 0;
    for (int i = 0; i < nb; i++) begin
      ba   = a + i;
      w    = ba & 32'hFFFF_FFFC;
      lane = int'(ba & 32'd3);
      if (e_n == 0 || e_addr[e_n-1] != w) begin
        e_addr[e_n] = w;
        e_strb[e_n] = 4'h0;
        e_data[e_n] = 32'h0;
        e_n++;
      end
      e_strb[e_n-1][lane]       = 1'b1;
      e_data[e_n-1][8*lane +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int dly0, input int dly1);
    int dly;
    @(negedge clk);
    chk("ready_before", st_ready, 1);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    @(posedge clk); #1;
    st_valid = 1'b0;
    if (f3 > 3'd2) begin
      chk("err_pulse", st_err, 1);
      chk("err_noreq", mem_req, 0);
      chk("err_ready", st_ready, 0);
      @(posedge clk); #1;
      chk("err_clear", st_err, 0);
      chk("err_noreq2", mem_req, 0);
      chk("err_ready2", st_ready, 1);
      return;
    end
    build_exp(f3, a, d);
    chk("busy_ready", st_ready, 0);
    for (int b = 0; b < e_n; b++) begin
      dly = (b == 0) ? dly0 : dly1;
      for (int c = 0; c <= dly; c++) begin
        chk("req", mem_req, 1);
        chk("addr", mem_addr, e_addr[b]);
        chk("strb", mem_wstrb, e_strb[b]);
        chk("wdata", mem_wdata, e_data[b]);
        chk("done_early", st_done, 0);
        chk("ready_busy", st_ready, 0);
        if (c == dly) begin
          mem_ack = 1'b1;
        end else begin
          // Requests presented while busy must be ignored.
          st_valid  = 1'($urandom_range(0, 1));
          st_funct3 = 3'($urandom);
          st_addr   = $urandom;
          st_data   = $urandom;
        end
        @(posedge clk); #1;
        mem_ack  = 1'b0;
        st_valid = 1'b0;
      end
    end
    chk("done_pulse", st_done, 1);
    chk("req_drop", mem_req, 0);
    chk("ready_resp", st_ready, 0);
    @(posedge clk); #1;
    chk("done_clear", st_done, 0);
    chk("ready_after", st_ready, 1);
  endtask

  initial begin
    logic [2:0] f3;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_funct3 = 3'd0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ack   = 1'b0;
    #2;
    chk("rst_ready", st_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_done", st_done, 0);
    chk("rst_err", st_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_store(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0);
    chk("sb_const_data", e_data[0], 32'hDD00_0000);
    do_store(3'b001, 32'h0000_2002, 32'h0000_1234, 0, 0);
    do_store(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1, 0);
    do_store(3'b010, 32'h0000_3001, 32'h1122_3344, 0, 0);
    chk("sw_split_beats", e_n, 2);
    do_store(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 3, 3);
    chk("wrap_addr", e_addr[1], 32'h0);
    mem_ack = 1'b1;
    do_store(3'b011, 32'h0000_4000, 32'h1234_5678, 0, 0);
    mem_ack = 1'b0;
    do_store(3'b000, 32'h0000_4001, 32'h0000_0077, 0, 0);

    // Reset while the second beat waits for its ack
    @(negedge clk);
    st_valid  = 1'b1;
    st_funct3 = 3'b010;
    st_addr   = 32'h0000_3001;
    st_data   = 32'h1122_3344;
    @(posedge clk); #1;
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("b1_req", mem_req, 1);
    chk("b1_addr", mem_addr, 32'h0000_3004);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_ready", st_ready, 1);
    chk("arst_done", st_done, 0);
    chk("arst_strb", mem_wstrb, 0);
    chk("arst_addr", mem_addr, 0);
    @(posedge clk); #1;
    chk("arst_done2", st_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_store(3'b010, 32'h0000_0000, 32'h5A5A_A5A5, 0, 0);

    // Randomized stores
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
      else                           f3 = 3'($urandom_range(0, 2));
      do_store(f3, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
